// File: rtl/calc_pkg.sv
// Shared key-code constants, FSM state encoding and key map
// for the keypad scanner.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam int NUM_DIGITS = 8;

  function automatic logic [3:0] key_map(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] k;
    k = KEY_0;
    unique case ({row, col})
      4'h0: k = KEY_1;
      4'h1: k = KEY_2;
      4'h2: k = KEY_3;
      4'h3: k = KEY_A;
      4'h4: k = KEY_4;
      4'h5: k = KEY_5;
      4'h6: k = KEY_6;
      4'h7: k = KEY_B;
      4'h8: k = KEY_7;
      4'h9: k = KEY_8;
      4'hA: k = KEY_9;
      4'hB: k = KEY_C;
      4'hC: k = KEY_STAR;
      4'hD: k = KEY_0;
      4'hE: k = KEY_HASH;
      4'hF: k = KEY_D;
    endcase
    return k;
  endfunction

  function automatic logic is_digit(input logic [3:0] k);
    return k <= KEY_9;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Ports: clk, rst (sync, active-high), d_i (async in), q_o (synced out).
module sync_2ff #(
  parameter int          W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with debounce and optional BCD entry
// accumulator (built when KEYPAD_ACCUM_EN is defined).
// Ports: clk, rst (sync, active-high), rows (active-low, async),
//   cols (active-low one-hot drive), key_code, key_valid (pulse),
//   num (8-digit BCD entry), num_ovf (sticky digit overflow).
module keypad_scan
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [31:0] num,
  output logic        num_ovf
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CNT) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CNT - 1);

  logic [3:0] rows_s;

  sync_2ff #(
    .W       (4),
    .RST_VAL (4'b1111)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rows),
    .q_o (rows_s)
  );

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic [3:0]        code_q, code_d;
  logic              kv_q, kv_d;

  logic              sample;
  logic [3:0]        row_low;
  logic              one_low;
  logic [1:0]        low_idx;
  logic [3:0]        row_pat;
  logic              all_high;

  // Rows settle for SCAN_DIV-1 cycles after a column change;
  // only the last cycle of the slot is used as a sample.
  assign sample = (div_q == DIV_LAST);
  assign div_d  = sample ? '0 : div_q + 1'b1;

  assign row_low  = ~rows_s;
  assign one_low  = $onehot(row_low);
  assign all_high = (rows_s == 4'b1111);
  assign row_pat  = ~(4'b0001 << row_q);

  always_comb begin
    low_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_low[i]) low_idx = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    kv_d    = 1'b0;
    if (sample) begin
      unique case (state_q)
        ST_SCAN: begin
          if (one_low) begin
            row_d   = low_idx;
            cnt_d   = DB_W'(1);
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (rows_s == row_pat) begin
            if (cnt_q == DB_LAST) begin
              kv_d    = 1'b1;
              code_d  = key_map(row_q, col_q);
              cnt_d   = '0;
              state_d = ST_PRESSED;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (all_high) begin
            cnt_d   = DB_W'(1);
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (all_high) begin
            if (cnt_q == DB_LAST) begin
              cnt_d   = '0;
              col_d   = col_q + 2'd1;
              state_d = ST_SCAN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_PRESSED;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SCAN;
      div_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= '0;
      code_q  <= 4'h0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      kv_q    <= kv_d;
    end
  end

  assign cols      = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = kv_q;

`ifdef KEYPAD_ACCUM_EN
  logic [31:0] num_q, num_d;
  logic [3:0]  dig_q, dig_d;
  logic        ovf_q, ovf_d;

  // Updates on the same edge that raises key_valid.
  always_comb begin
    num_d = num_q;
    dig_d = dig_q;
    ovf_d = ovf_q;
    if (kv_d) begin
      if (code_d == KEY_STAR) begin
        num_d = '0;
        dig_d = '0;
        ovf_d = 1'b0;
      end else if (is_digit(code_d)) begin
        if (dig_q < 4'(NUM_DIGITS)) begin
          num_d = {num_q[27:0], code_d};
          dig_d = dig_q + 4'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q <= '0;
      dig_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      num_q <= num_d;
      dig_q <= dig_d;
      ovf_q <= ovf_d;
    end
  end

  assign num     = num_q;
  assign num_ovf = ovf_q;
`else
  assign num     = '0;
  assign num_ovf = 1'b0;
`endif

endmodule
